stream_alu_pipe: RTL and testbench
==================================

Name: stream_alu_pipe

Overview:
- Parametrised successor to the two-operand streaming adder that sits between the source fence and the sink in the vector FPU streamer.
- Joins NB_OPERANDS operand streams and applies a runtime-selected lane-wise integer op, folded across operands.
- Pushes results through a stallable PIPE_STAGES-deep pipeline to the result stream.
- A job FSM counts beats per job and pulses done for the controller.

Parameters:
- DATA_WIDTH, 32: stream data width in bits; multiple of LANE_WIDTH and of 8.
- LANE_WIDTH, 32: SIMD lane width in bits; legal values 8, 16, 32.
- NB_OPERANDS, 2: number of operand streams; legal range 2..4.
- PIPE_STAGES, 2: result pipeline register stages; legal range 1..4.
- LEN_WIDTH, 16: width of the job length and beat counters.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous clear.
- start_i  in  1  job start, sampled in IDLE only.
- op_i  in  3  opcode: 0 ADD, 1 SUB, 2 MIN signed, 3 MAX signed, 4 AND, 5 OR, 6 XOR, 7 PASS (operand 0).
- len_i  in  LEN_WIDTH  job length in beats.
- op_valid_i  in  NB_OPERANDS  per-operand valid.
- op_ready_o  out  NB_OPERANDS  per-operand ready.
- op_data_i  in  NB_OPERANDS*DATA_WIDTH  operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- op_strb_i  in  NB_OPERANDS*DATA_WIDTH/8  byte strobes, packed the same way.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_data_o  out  DATA_WIDTH  result data.
- res_strb_o  out  DATA_WIDTH/8  result strobe.
- busy_o  out  1  high in RUN or DRAIN.
- done_o  out  1  one-cycle pulse at job end.
- beat_cnt_o  out  LEN_WIDTH  result beats handshaked in the current job.

Behaviour:
- Reset (rst_i=1, asynchronous): FSM to IDLE; all pipeline valids 0; counters 0; op/len registers 0. All outputs 0: op_ready_o, res_valid_o, res_data_o, res_strb_o, busy_o, done_o, beat_cnt_o.
- clear_i (synchronous): same state as reset on the next edge; has priority over start_i and over any handshake that cycle; no done pulse.
- FSM states:
  - IDLE: on start_i, latch op_i and len_i and zero the counters. If len_i==0, pulse done_o next cycle and stay IDLE; otherwise go to RUN. op_i and len_i are ignored outside IDLE.
  - RUN: accept input beats. When accepted count reaches len, go to DRAIN on the same edge as the last accept.
  - DRAIN: no input accepted. When the pipeline is empty and the last result has handshaked, return to IDLE and assert done_o for exactly one cycle on that transition.
  - start_i in RUN or DRAIN is ignored.
- Join:
  - in_fire = (state==RUN) & all op_valid_i & s0_ready.
  - op_ready_o[k] = (state==RUN) & s0_ready & (all op_valid_i) for every k, so all operands are consumed in the same cycle.
  - A valid held on a subset of operands is never consumed.
- Compute (combinational before stage 0):
  - Per lane r = f(...f(f(a0,a1),a2)...,aN-1).
  - SUB gives a0-a1-..., wraps modulo 2^LANE_WIDTH.
  - ADD wraps modulo 2^LANE_WIDTH.
  - MIN/MAX use two's-complement signed compare per lane.
  - PASS outputs a0.
  - res strobe = bitwise AND of all operand strobes.
- Pipeline:
  - Stage k register loads when ready_k = !valid_k | ready_{k+1}; the last stage's ready_{k+1} is res_ready_i.
  - Full throughput 1 beat/cycle under no backpressure.
  - Latency from in_fire to res_valid_o is PIPE_STAGES cycles.
  - res_valid_o, res_data_o and res_strb_o are held stable while res_valid_o & !res_ready_i.
  - No beat is dropped or duplicated under any stall pattern.
- Counters: accepted-beat counter (internal) and beat_cnt_o both increment on their respective handshakes. beat_cnt_o holds its final value in IDLE until the next start_i or clear_i.
- Simultaneous events:
  - Last input accept and an output handshake in the same cycle are both counted.
  - Output handshake and a new stage load in the same cycle pass through without a bubble.

Test Plan:
- Basic ADD, NB_OPERANDS=2, LANE_WIDTH=32, len=4: a=1,2,3,4, b=10,20,30,40, res_ready tied 1 -> res 11,22,33,44; first res_valid exactly 2 cycles after first accept; done_o single pulse after the 4th beat; beat_cnt_o=4.
- SUB and MIN with NB_OPERANDS=3, LANE_WIDTH=8, one beat, operands 0x05_80_00_10, 0x06_01_01_01, 0x01_7F_FF_02 -> SUB 0xFE_00_00_0D; MIN 0x01_80_FF_01.
- Backpressure: len=8, res_ready_i pattern 1,0,0,1,0,1... -> output sequence identical to the input order, no loss or duplication; res_data_o stable while stalled; done_o only after the 8th output handshake.
- Skewed valids: op_valid_i[0] high for 3 cycles before op_valid_i[1] -> no op_ready_o until both are valid, then exactly one beat consumed from each.
- len=0 start -> done_o pulse next cycle, busy_o stays 0, op_ready_o stays 0. start_i asserted during RUN -> ignored, job length unchanged.
- rst_i asserted mid-DRAIN with 2 beats in flight -> res_valid_o, busy_o and beat_cnt_o 0 immediately (asynchronous). After release, a new job runs correctly. Repeat with clear_i and check the same result on the next edge with no done_o.

Source files
------------

// File: rtl/stream_alu_pipe.sv
// Stream ALU pipeline: joins NB_OPERANDS operand streams, folds a lane-wise integer op across them
// and pushes results through a stallable pipeline, with a job FSM that counts beats and pulses done.
module stream_alu_pipe #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned LANE_WIDTH  = 32,
   parameter int unsigned NB_OPERANDS = 2,
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clear_i,
   input  logic                                start_i,
   input  logic [2:0]                          op_i,
   input  logic [LEN_WIDTH-1:0]                len_i,
   input  logic [NB_OPERANDS-1:0]              op_valid_i,
   output logic [NB_OPERANDS-1:0]              op_ready_o,
   input  logic [NB_OPERANDS*DATA_WIDTH-1:0]   op_data_i,
   input  logic [NB_OPERANDS*DATA_WIDTH/8-1:0] op_strb_i,
   output logic                                res_valid_o,
   input  logic                                res_ready_i,
   output logic [DATA_WIDTH-1:0]               res_data_o,
   output logic [DATA_WIDTH/8-1:0]             res_strb_o,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [LEN_WIDTH-1:0]                beat_cnt_o
);

   localparam int unsigned NB_LANES   = DATA_WIDTH / LANE_WIDTH;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [PIPE_STAGES-1:0] LAST_ONLY = PIPE_STAGES'(1) << (PIPE_STAGES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MIN, OP_MAX, OP_AND, OP_OR, OP_XOR, OP_PASS} op_t;

   state_t                 state;
   op_t                    op_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   accept_cnt;
   logic [LEN_WIDTH-1:0]   beat_cnt;
   logic                   done_q;

   logic [PIPE_STAGES-1:0] pipe_valid;
   logic [DATA_WIDTH-1:0]  pipe_data [PIPE_STAGES];
   logic [STRB_WIDTH-1:0]  pipe_strb [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] stage_ready;

   logic [DATA_WIDTH-1:0]  comp_data;
   logic [STRB_WIDTH-1:0]  comp_strb;
   logic                   in_fire;
   logic                   out_fire;
   logic                   drain_done;

   function automatic logic [LANE_WIDTH-1:0] lane_op(input op_t op,
                                                     input logic [LANE_WIDTH-1:0] a,
                                                     input logic [LANE_WIDTH-1:0] b);
      logic [LANE_WIDTH-1:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
         OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = a;
      endcase
      return r;
   endfunction

   always_comb begin
      logic [LANE_WIDTH-1:0] acc;
      acc       = '0;
      comp_data = '0;
      comp_strb = '1;
      for (int unsigned l = 0; l < NB_LANES; l++) begin
         acc = op_data_i[l*LANE_WIDTH +: LANE_WIDTH];
         for (int unsigned k = 1; k < NB_OPERANDS; k++)
            acc = lane_op(op_q, acc, op_data_i[k*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH]);
         comp_data[l*LANE_WIDTH +: LANE_WIDTH] = acc;
      end
      for (int unsigned k = 0; k < NB_OPERANDS; k++)
         comp_strb = comp_strb & op_strb_i[k*STRB_WIDTH +: STRB_WIDTH];
   end

   // ready_k = !valid_k | ready_{k+1}, unrolled as "some stage at or after k is empty, or sink ready"
   always_comb begin
      logic full_above;
      full_above  = 1'b1;
      stage_ready = '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
         full_above = full_above & pipe_valid[PIPE_STAGES-1-i];
         stage_ready[PIPE_STAGES-1-i] = res_ready_i | !full_above;
      end
   end

   assign in_fire    = (state == RUN) & (&op_valid_i) & stage_ready[0];
   assign out_fire   = pipe_valid[PIPE_STAGES-1] & res_ready_i;
   assign drain_done = (pipe_valid == '0) | ((pipe_valid == LAST_ONLY) & res_ready_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            pipe_data[i] <= '0;
            pipe_strb[i] <= '0;
         end
      end else if (clear_i) begin
         pipe_valid <= '0;
         for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            pipe_data[i] <= '0;
            pipe_strb[i] <= '0;
         end
      end else begin
         if (stage_ready[0]) begin
            pipe_valid[0] <= in_fire;
            if (in_fire) begin
               pipe_data[0] <= comp_data;
               pipe_strb[0] <= comp_strb;
            end
         end
         for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            if (stage_ready[i]) begin
               pipe_valid[i] <= pipe_valid[i-1];
               if (pipe_valid[i-1]) begin
                  pipe_data[i] <= pipe_data[i-1];
                  pipe_strb[i] <= pipe_strb[i-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         op_q       <= OP_ADD;
         len_q      <= '0;
         accept_cnt <= '0;
         beat_cnt   <= '0;
         done_q     <= 1'b0;
      end else if (clear_i) begin
         state      <= IDLE;
         op_q       <= OP_ADD;
         len_q      <= '0;
         accept_cnt <= '0;
         beat_cnt   <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (out_fire)
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
         case (state)
            IDLE: begin
               if (start_i) begin
                  op_q       <= op_t'(op_i);
                  len_q      <= len_i;
                  accept_cnt <= '0;
                  beat_cnt   <= '0;
                  if (len_i == '0)
                     done_q <= 1'b1;
                  else
                     state <= RUN;
               end
            end
            RUN: begin
               if (in_fire) begin
                  accept_cnt <= accept_cnt + LEN_WIDTH'(1);
                  if (accept_cnt + LEN_WIDTH'(1) == len_q)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign op_ready_o  = {NB_OPERANDS{in_fire}};
   assign res_valid_o = pipe_valid[PIPE_STAGES-1];
   assign res_data_o  = pipe_data[PIPE_STAGES-1];
   assign res_strb_o  = pipe_strb[PIPE_STAGES-1];
   assign busy_o      = (state != IDLE);
   assign done_o      = done_q;
   assign beat_cnt_o  = beat_cnt;

endmodule

// File: tb/tb_stream_alu_pipe.sv
// Scoreboard bench for stream_alu_pipe: three 8-bit-lane operand streams, random stimulus checked
// against a per-lane arithmetic reference model, with backpressure, skew, reset and clear scenarios.
module tb_stream_alu_pipe;
   localparam int unsigned DW   = 32;
   localparam int unsigned LW   = 8;
   localparam int unsigned NB   = 3;
   localparam int unsigned PS   = 2;
   localparam int unsigned LENW = 16;
   localparam int unsigned SW   = DW / 8;

   logic              clk = 1'b0;
   logic              rst_i, clear_i, start_i;
   logic [2:0]        op_i;
   logic [LENW-1:0]   len_i;
   logic [NB-1:0]     op_valid_i, op_ready_o;
   logic [NB*DW-1:0]  op_data_i;
   logic [NB*SW-1:0]  op_strb_i;
   logic              res_valid_o, res_ready_i;
   logic [DW-1:0]     res_data_o;
   logic [SW-1:0]     res_strb_o;
   logic              busy_o, done_o;
   logic [LENW-1:0]   beat_cnt_o;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int done_count = 0;
   int first_acc_cyc = -1, last_acc_cyc = -1, first_valid_cyc = -1;
   int bp_mode = 0;
   logic man_ready = 1'b0;
   logic [2:0] job_op;
   logic [SW+DW-1:0] sb[$];

   stream_alu_pipe #(
      .DATA_WIDTH(DW), .LANE_WIDTH(LW), .NB_OPERANDS(NB), .PIPE_STAGES(PS), .LEN_WIDTH(LENW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .op_i(op_i), .len_i(len_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i), .op_strb_i(op_strb_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_strb_o(res_strb_o), .busy_o(busy_o), .done_o(done_o), .beat_cnt_o(beat_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: each lane is the fold of the op over all operands, done in plain integers.
   function automatic logic [SW+DW-1:0] model(input logic [2:0] op, input logic [NB*DW-1:0] d,
                                              input logic [NB*SW-1:0] s);
      logic [DW-1:0] r;
      logic [SW-1:0] st;
      int v[NB];
      int acc;
      r  = '0;
      st = '1;
      for (int k = 0; k < NB; k++) st &= s[k*SW +: SW];
      for (int l = 0; l < DW/LW; l++) begin
         for (int k = 0; k < NB; k++) begin
            v[k] = int'(d[k*DW + l*LW +: LW]);
            if ((op == 3'd2 || op == 3'd3) && v[k] >= (1 << (LW-1))) v[k] -= (1 << LW);
         end
         acc = v[0];
         for (int k = 1; k < NB; k++) begin
            case (op)
               3'd0: acc = acc + v[k];
               3'd1: acc = acc - v[k];
               3'd2: if (v[k] < acc) acc = v[k];
               3'd3: if (v[k] > acc) acc = v[k];
               3'd4: acc = acc & v[k];
               3'd5: acc = acc | v[k];
               3'd6: acc = acc ^ v[k];
               default: ;
            endcase
         end
         r[l*LW +: LW] = LW'(acc);
      end
      return {st, r};
   endfunction

   initial begin : ready_drv
      int pi;
      bit pat[6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      pi = 0;
      res_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0: res_ready_i = 1'b1;
            1: begin res_ready_i = pat[pi]; pi = (pi + 1) % 6; end
            2: res_ready_i = 1'($urandom_range(0, 1));
            default: res_ready_i = man_ready;
         endcase
      end
   end

   initial begin : monitor
      logic stalled;
      logic [DW-1:0] pd;
      logic [SW-1:0] ps;
      logic [SW+DW-1:0] e;
      stalled = 1'b0;
      pd = '0;
      ps = '0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("hold_valid", 64'(res_valid_o), 64'd1);
               check("hold_data", 64'(res_data_o), 64'(pd));
               check("hold_strb", 64'(res_strb_o), 64'(ps));
            end
            if (res_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (res_valid_o && res_ready_i) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_result: got 0x%0h, expected no beat", res_data_o);
               end else begin
                  e = sb.pop_front();
                  check("res_data", 64'(res_data_o), 64'(e[DW-1:0]));
                  check("res_strb", 64'(res_strb_o), 64'(e[SW+DW-1:DW]));
               end
            end
            stalled = res_valid_o && !res_ready_i && !clear_i;
            pd = res_data_o;
            ps = res_strb_o;
         end
      end
   end

   initial begin : done_watch
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done_o) begin
            done_count++;
            check("done_single_pulse", 64'(prev), 64'd0);
            check("done_after_last_beat", 64'(sb.size()), 64'd0);
         end
         prev = done_o;
      end
   end

   task automatic start_job(input logic [2:0] op, input int len);
      @(posedge clk); #1;
      start_i = 1'b1;
      op_i    = op;
      len_i   = LENW'(len);
      job_op  = op;
      @(posedge clk); #1;
      start_i = 1'b0;
      op_i    = 3'($urandom);
      len_i   = LENW'($urandom);
   endtask

   // Call only at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send_beat(input logic [NB*DW-1:0] d, input logic [NB*SW-1:0] s,
                            input logic [SW+DW-1:0] exp);
      op_data_i  = d;
      op_strb_i  = s;
      op_valid_i = '1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (op_ready_o == '1) begin
            sb.push_back(exp);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            @(posedge clk); #1;
            op_valid_i = '0;
            return;
         end
      end
      check("accept_timeout", 64'(op_ready_o), 64'(3'b111));
      op_valid_i = '0;
   endtask

   task automatic send_random(input logic [2:0] op);
      logic [NB*DW-1:0] d;
      logic [NB*SW-1:0] s;
      d = {$urandom, $urandom, $urandom};
      s = NB*SW'($urandom) | NB*SW'($urandom);
      send_beat(d, s, model(op, d, s));
   endtask

   task automatic wait_done(input int len);
      int n;
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (done_o) break;
      end
      if (n == 2000) check("done_timeout", 64'(done_o), 64'd1);
      check("done_beat_cnt", 64'(beat_cnt_o), 64'(len));
      check("done_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      check("done_cleared", 64'(done_o), 64'd0);
      check("beat_cnt_hold", 64'(beat_cnt_o), 64'(len));
   endtask

   // Leaves a 3-beat XOR job in DRAIN with one beat delivered and two still in the pipeline.
   task automatic drain_setup();
      bp_mode   = 3;
      man_ready = 1'b0;
      start_job(3'd6, 3);
      send_random(3'd6);
      send_random(3'd6);
      @(negedge clk); man_ready = 1'b1;
      @(negedge clk); man_ready = 1'b0;
      @(posedge clk); #1;
      send_random(3'd6);
      @(negedge clk);
      check("setup_busy", 64'(busy_o), 64'd1);
      check("setup_res_valid", 64'(res_valid_o), 64'd1);
      check("setup_beat_cnt", 64'(beat_cnt_o), 64'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int dc, len;
      rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; op_i = '0; len_i = '0;
      op_valid_i = '0; op_data_i = '0; op_strb_i = '0; job_op = '0;
      repeat (3) @(negedge clk);
      check("rst_op_ready", 64'(op_ready_o), 64'd0);
      check("rst_res_valid", 64'(res_valid_o), 64'd0);
      check("rst_res_data", 64'(res_data_o), 64'd0);
      check("rst_res_strb", 64'(res_strb_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
      @(posedge clk); #1 rst_i = 1'b0;

      // Basic ADD, back-to-back, with an ignored start pulse mid-job
      bp_mode = 0;
      first_acc_cyc = -1; first_valid_cyc = -1;
      start_job(3'd0, 4);
      for (int i = 1; i <= 4; i++) begin
         if (i == 3) begin start_i = 1'b1; op_i = 3'd6; len_i = 16'd1; end
         send_beat({32'h0, 32'(10*i), 32'(i)}, '1, {4'hF, 32'(11*i)});
         start_i = 1'b0;
      end
      wait_done(4);
      check("first_latency", 64'(first_valid_cyc - first_acc_cyc), 64'd2);
      check("throughput", 64'(last_acc_cyc - first_acc_cyc), 64'd3);

      // SUB and MIN on 8-bit lanes
      start_job(3'd1, 1);
      send_beat({32'h017FFF02, 32'h06010101, 32'h05800010}, {4'hE, 4'hB, 4'hF}, {4'hA, 32'hFE00000D});
      wait_done(1);
      start_job(3'd2, 1);
      send_beat({32'h017FFF02, 32'h06010101, 32'h05800010}, '1, {4'hF, 32'h0180FF01});
      wait_done(1);

      // Backpressure pattern 1,0,0,1,0,1...
      bp_mode = 1;
      start_job(3'd0, 8);
      for (int i = 0; i < 8; i++) send_random(3'd0);
      wait_done(8);
      bp_mode = 0;

      // Skewed valids: a partial set of valids is never consumed
      start_job(3'd5, 1);
      op_data_i = {$urandom, $urandom, $urandom};
      op_valid_i = 3'b001;
      repeat (3) begin
         @(negedge clk);
         check("skew_no_ready", 64'(op_ready_o), 64'd0);
      end
      @(posedge clk); #1 op_valid_i = 3'b011;
      @(negedge clk);
      check("skew_partial_no_ready", 64'(op_ready_o), 64'd0);
      @(posedge clk); #1;
      send_random(3'd5);
      wait_done(1);

      // Zero-length job
      op_valid_i = '1;
      dc = done_count;
      start_job(3'd0, 0);
      @(negedge clk);
      check("len0_done", 64'(done_o), 64'd1);
      check("len0_busy", 64'(busy_o), 64'd0);
      check("len0_op_ready", 64'(op_ready_o), 64'd0);
      @(negedge clk);
      check("len0_done_cleared", 64'(done_o), 64'd0);
      check("len0_busy_after", 64'(busy_o), 64'd0);
      check("len0_op_ready_after", 64'(op_ready_o), 64'd0);
      check("len0_beat_cnt", 64'(beat_cnt_o), 64'd0);
      check("len0_done_count", 64'(done_count - dc), 64'd1);
      op_valid_i = '0;

      // Random jobs, random ops, random stalls and input gaps
      for (int j = 0; j < 12; j++) begin
         len = $urandom_range(1, 10);
         bp_mode = $urandom_range(0, 2);
         start_job(3'($urandom_range(0, 7)), len);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send_random(job_op);
         end
         wait_done(len);
      end

      // Asynchronous reset in DRAIN with two beats in flight
      drain_setup();
      @(posedge clk); #3 rst_i = 1'b1;
      #1;
      check("arst_res_valid", 64'(res_valid_o), 64'd0);
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_beat_cnt", 64'(beat_cnt_o), 64'd0);
      check("arst_done", 64'(done_o), 64'd0);
      sb.delete();
      @(posedge clk); #1 rst_i = 1'b0;
      bp_mode = 2;
      start_job(3'd3, 5);
      for (int b = 0; b < 5; b++) send_random(3'd3);
      wait_done(5);

      // Synchronous clear in DRAIN, also beating a simultaneous start
      drain_setup();
      dc = done_count;
      @(posedge clk); #1;
      clear_i = 1'b1; start_i = 1'b1; op_i = 3'd0; len_i = 16'd5;
      @(negedge clk);
      check("clr_sync_busy", 64'(busy_o), 64'd1);
      check("clr_sync_valid", 64'(res_valid_o), 64'd1);
      @(posedge clk); #1;
      clear_i = 1'b0; start_i = 1'b0;
      check("clr_res_valid", 64'(res_valid_o), 64'd0);
      check("clr_busy", 64'(busy_o), 64'd0);
      check("clr_beat_cnt", 64'(beat_cnt_o), 64'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      check("clr_no_done", 64'(done_count), 64'(dc));
      check("clr_stays_idle", 64'(busy_o), 64'd0);
      bp_mode = 1;
      start_job(3'd4, 4);
      for (int b = 0; b < 4; b++) send_random(3'd4);
      wait_done(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
